lives_ctrl: RTL and testbench

Game-level lives controller that owns the player's life count and drives the `len` input of the on-screen hearts row. It sequences game start, life loss with a frame-timed invulnerability window, extra lives and game over. The lost heart blinks during invulnerability. It sits between the game-logic collision/score blocks and the hearts display generator. All outputs are registered.

---
 rtl/lives_ctrl_pkg.sv | 14 +
 rtl/lives_ctrl_if.sv | 25 ++
 rtl/lives_ctrl_countdown.sv | 34 +++
 rtl/lives_ctrl.sv | 140 ++++++++++++++
 tb/tb_lives_ctrl.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/lives_ctrl_pkg.sv
// game_pkg: shared game-level types and widths for lives_ctrl,
// the hearts display and the score blocks.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    HIT,
    OVER
  } lives_state_t;

  localparam int LIVES_W = 3;

endpackage

// File: rtl/lives_ctrl_if.sv
// lives_ctrl_if: game-logic pulses into lives_ctrl and the
// registered life/hearts status back out.
interface lives_ctrl_if;
  import game_pkg::*;

  logic               start_game;
  logic               frame_tick;
  logic               life_lost;
  logic               extra_life;
  logic [LIVES_W-1:0] len;
  logic [LIVES_W-1:0] lives;
  logic               invulnerable;
  logic               game_over;

  modport master (
    output start_game, frame_tick, life_lost, extra_life,
    input  len, lives, invulnerable, game_over
  );

  modport slave (
    input  start_game, frame_tick, life_lost, extra_life,
    output len, lives, invulnerable, game_over
  );

endinterface

// File: rtl/lives_ctrl_countdown.sv
// frame_countdown: loadable frame down-counter that stops at 0.
// last_o flags that the next tick reaches 0.
module frame_countdown #(
  parameter int unsigned LOAD = 8,
  parameter int unsigned W    = $clog2(LOAD + 1)
) (
  input  logic clk,
  input  logic resetN,
  input  logic clr_i,
  input  logic load_i,
  input  logic tick_i,
  output logic zero_o,
  output logic last_o
);

  logic [W-1:0] cnt_q;

  // Clear beats load beats tick; never wraps below zero.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= W'(LOAD);
    end else if (tick_i && cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);
  assign last_o = (cnt_q == W'(1));

endmodule

// File: rtl/lives_ctrl.sv
// lives_ctrl: life count, invulnerability window and hearts len.
// Define LIVES_BLINK_EN to build the blinking lost heart.
module lives_ctrl
  import game_pkg::*;
#(
  parameter int unsigned INIT_LIVES    = 3,
  parameter int unsigned MAX_LIVES     = 5,
  parameter int unsigned INVULN_FRAMES = 120,
  parameter int unsigned BLINK_FRAMES  = 8
) (
  input logic         clk,
  input logic         resetN,
  lives_ctrl_if.slave bus
);

  lives_state_t       state_q, state_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic [LIVES_W-1:0] len_q, len_d;
  logic [LIVES_W-1:0] lives_inc;
  logic               inv_q, over_q;
  logic               clr, enter_hit, tick_hit;
  logic               inv_zero, inv_last, inv_done;
  logic               blink_add;

  assign tick_hit = bus.frame_tick && !bus.start_game
                    && (state_q == HIT);
  assign inv_done = (tick_hit && inv_last)
                    || ((state_q == HIT) && inv_zero);
  assign lives_inc = (lives_q < LIVES_W'(MAX_LIVES))
                     ? lives_q + 1'b1 : lives_q;

  frame_countdown #(.LOAD(INVULN_FRAMES)) u_inv (
    .clk    (clk),
    .resetN (resetN),
    .clr_i  (clr),
    .load_i (enter_hit),
    .tick_i (tick_hit),
    .zero_o (inv_zero),
    .last_o (inv_last)
  );

`ifdef LIVES_BLINK_EN
  logic ph_q, ph_d;
  logic bl_zero, bl_last, bl_wrap;

  assign bl_wrap = (tick_hit && bl_last)
                   || ((state_q == HIT) && bl_zero);

  frame_countdown #(.LOAD(BLINK_FRAMES)) u_blink (
    .clk    (clk),
    .resetN (resetN),
    .clr_i  (clr),
    .load_i (enter_hit || bl_wrap),
    .tick_i (tick_hit),
    .zero_o (bl_zero),
    .last_o (bl_last)
  );

  // Blink phase: ON at hit entry, toggles every half-period.
  always_comb begin
    ph_d = ph_q;
    if (clr)            ph_d = 1'b0;
    else if (enter_hit) ph_d = 1'b1;
    else if (bl_wrap)   ph_d = ~ph_q;
  end

  // Blink phase register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) ph_q <= 1'b0;
    else         ph_q <= ph_d;
  end

  assign blink_add = ph_d && (state_d == HIT)
                     && (lives_d < LIVES_W'(MAX_LIVES));
`else
  assign blink_add = 1'b0;
`endif

  // Next state and life count; start_game overrides everything.
  always_comb begin
    state_d   = state_q;
    lives_d   = lives_q;
    clr       = 1'b0;
    enter_hit = 1'b0;
    if (bus.start_game) begin
      state_d = PLAY;
      lives_d = LIVES_W'(INIT_LIVES);
      clr     = 1'b1;
    end else begin
      unique case (state_q)
        PLAY: begin
          if (bus.life_lost) begin
            if (lives_q == LIVES_W'(1) && !bus.extra_life) begin
              lives_d = '0;
              state_d = OVER;
            end else begin
              lives_d   = bus.extra_life ? lives_q
                                         : lives_q - 1'b1;
              state_d   = HIT;
              enter_hit = 1'b1;
            end
          end else if (bus.extra_life) begin
            lives_d = lives_inc;
          end
        end
        HIT: begin
          if (bus.extra_life) lives_d = lives_inc;
          if (inv_done)       state_d = PLAY;
        end
        default: ;
      endcase
    end
  end

  assign len_d = ((state_d == PLAY) || (state_d == HIT))
                 ? lives_d + LIVES_W'(blink_add) : '0;

  // State and registered outputs.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= IDLE;
      lives_q <= '0;
      len_q   <= '0;
      inv_q   <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lives_q <= lives_d;
      len_q   <= len_d;
      inv_q   <= (state_d == HIT);
      over_q  <= (state_d == OVER);
    end
  end

  assign bus.lives        = lives_q;
  assign bus.len          = len_q;
  assign bus.invulnerable = inv_q;
  assign bus.game_over    = over_q;

endmodule

// File: tb/tb_lives_ctrl.sv
// tb_lives_ctrl: directed stimulus with a queued scoreboard
// checked by a per-cycle monitor.
module tb_lives_ctrl;

`ifdef LIVES_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  typedef struct {
    int       due;
    string    nm;
    logic [2:0] lv;
    logic [2:0] ln;
    logic     inv;
    logic     go;
  } exp_t;

  exp_t q[$];
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_fail = 0;

  lives_ctrl_if bus();

  lives_ctrl #(
    .INIT_LIVES    (3),
    .MAX_LIVES     (5),
    .INVULN_FRAMES (120),
    .BLINK_FRAMES  (8)
  ) dut (
    .clk    (clk),
    .resetN (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int elen(int lv, bit hit, int t);
    if (BLINK && hit && ((t / 8) % 2 == 0) && lv < 5)
      return lv + 1;
    return lv;
  endfunction

  task automatic cmp(string nm, logic [2:0] lv, logic [2:0] ln,
                     logic inv, logic go);
    n_chk++;
    if (bus.lives !== lv || bus.len !== ln ||
        bus.invulnerable !== inv || bus.game_over !== go) begin
      n_fail++;
      $display("FAIL %s @%0d: got lives=%0d len=%0d inv=%0b over=%0b, want lives=%0d len=%0d inv=%0b over=%0b",
               nm, cyc, bus.lives, bus.len, bus.invulnerable,
               bus.game_over, lv, ln, inv, go);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    while (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      cmp(e.nm, e.lv, e.ln, e.inv, e.go);
    end
  end

  task automatic drive(bit s, bit t, bit l, bit x, bit chk,
                       string nm, int lv, int ln, bit inv, bit go);
    exp_t e;
    @(negedge clk);
    bus.start_game = s;
    bus.frame_tick = t;
    bus.life_lost  = l;
    bus.extra_life = x;
    if (chk) begin
      e.due = cyc + 1;
      e.nm  = nm;
      e.lv  = 3'(lv);
      e.ln  = 3'(ln);
      e.inv = inv;
      e.go  = go;
      q.push_back(e);
    end
  endtask

  task automatic ticks(int n, string nm, int lv);
    for (int i = 1; i <= n; i++)
      drive(0, 1, 0, 0, i == n, nm, lv, lv, 0, 0);
  endtask

  initial begin
    bus.start_game = 1'b0;
    bus.frame_tick = 1'b0;
    bus.life_lost  = 1'b0;
    bus.extra_life = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    drive(0, 0, 0, 0, 1, "reset", 0, 0, 0, 0);
    drive(1, 0, 0, 0, 1, "start", 3, 3, 0, 0);
    drive(0, 1, 1, 0, 1, "hit_entry", 2, elen(2, 1, 0), 1, 0);
    drive(0, 0, 1, 0, 1, "ll_in_hit", 2, elen(2, 1, 0), 1, 0);
    for (int i = 1; i <= 120; i++)
      drive(0, 1, 0, 0, 1, "blink", 2,
            (i < 120) ? elen(2, 1, i) : 2, i < 120, 0);

    drive(0, 0, 1, 0, 1, "hit2", 1, elen(1, 1, 0), 1, 0);
    ticks(120, "expire2", 1);
    drive(0, 0, 1, 0, 1, "over", 0, 0, 0, 1);
    drive(0, 1, 1, 1, 1, "over_hold", 0, 0, 0, 1);
    drive(1, 0, 0, 0, 1, "restart", 3, 3, 0, 0);

    for (int k = 1; k <= 4; k++)
      drive(0, 0, 0, 1, 1, "xl_sat",
            (3 + k > 5) ? 5 : 3 + k, (3 + k > 5) ? 5 : 3 + k, 0, 0);

    drive(0, 0, 1, 0, 1, "hit5", 4, elen(4, 1, 0), 1, 0);
    drive(0, 0, 0, 1, 1, "xl_hit", 5, 5, 1, 0);
    drive(0, 0, 0, 1, 1, "xl_hit_sat", 5, 5, 1, 0);
    ticks(120, "expire5", 5);

    for (int lv = 5; lv >= 2; lv--) begin
      drive(0, 0, 1, 0, 1, "ll_down", lv - 1,
            elen(lv - 1, 1, 0), 1, 0);
      ticks(120, "expire_down", lv - 1);
    end

    drive(0, 0, 1, 1, 1, "ll_xl_at1", 1, elen(1, 1, 0), 1, 0);
    drive(1, 0, 1, 0, 1, "start_in_hit", 3, 3, 0, 0);
    drive(0, 0, 1, 0, 1, "hit_again", 2, elen(2, 1, 0), 1, 0);
    drive(0, 1, 0, 0, 1, "tick_in_hit", 2, elen(2, 1, 1), 1, 0);

    @(negedge clk);
    bus.frame_tick = 1'b1;
    #2 rst_n = 1'b0;
    #1 cmp("async_rst", 0, 0, 0, 0);
    @(negedge clk);
    cmp("rst_held", 0, 0, 0, 0);
    bus.frame_tick = 1'b0;
    rst_n = 1'b1;

    drive(0, 1, 0, 0, 1, "idle_tick", 0, 0, 0, 0);
    drive(0, 0, 1, 1, 1, "idle_ll_xl", 0, 0, 0, 0);
    drive(1, 0, 0, 0, 1, "start_after_rst", 3, 3, 0, 0);
    drive(0, 0, 0, 0, 0, "", 0, 0, 0, 0);

    repeat (3) @(negedge clk);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d pending, want 0", q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
